dot_accumulator: RTL and testbench

DOT_ACCUMULATOR -- requirements
Module: dot_accumulator

---
 rtl/dot_accumulator.sv | 104 ++++++++++
 tb/tb_dot_accumulator.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dot_accumulator.sv
// Streaming dot-product accumulator: sums LEN unsigned products per frame,
// saturating on overflow, and presents each frame result on a valid/ready port.
module dot_accumulator #(
    parameter int LEN   = 8,
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_prod,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam int CW = $clog2(LEN);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             sovf_q, sovf_d;

    logic             hs;
    logic             last;
    logic             close;
    logic [ACC_W:0]   add;
    logic [ACC_W-1:0] acc_nx;
    logic             ovf_nx;

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign out_sum   = sum_q;
    assign out_ovf   = sovf_q;

    // Extra carry bit detects wrap so the sum can pin at all ones.
    assign add    = {1'b0, acc_q} + {1'b0, ACC_W'(in_prod)};
    assign acc_nx = add[ACC_W] ? {ACC_W{1'b1}} : add[ACC_W-1:0];
    assign ovf_nx = ovf_q | add[ACC_W];

    assign hs    = in_valid & in_ready;
    assign last  = (cnt_q == CW'(LEN - 1));
    assign close = (state_q == ACCUM)
                 & ((hs & last) | (flush & (hs | (cnt_q != '0))));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        sum_d   = sum_q;
        sovf_d  = sovf_q;
        unique case (state_q)
            ACCUM: begin
                if (close) begin
                    sum_d   = hs ? acc_nx : acc_q;
                    sovf_d  = hs ? ovf_nx : ovf_q;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = HOLD;
                end else if (hs) begin
                    acc_d = acc_nx;
                    cnt_d = cnt_q + CW'(1);
                    ovf_d = ovf_nx;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            sum_q   <= '0;
            sovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            sum_q   <= sum_d;
            sovf_q  <= sovf_d;
        end
    end

endmodule

// File: tb/tb_dot_accumulator.sv
// Directed bench for dot_accumulator: three instances share stimulus,
// covering wide, narrow (saturating) and LEN=8 flush configurations.
module tb_dot_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_prod = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;

    logic        a_rdy, a_ov, a_ovf;
    logic [39:0] a_sum;
    logic        b_rdy, b_ov, b_ovf;
    logic [32:0] b_sum;
    logic        c_rdy, c_ov, c_ovf;
    logic [39:0] c_sum;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dot_accumulator #(.LEN(4), .ACC_W(40)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_rdy),
        .in_prod(in_prod), .flush(flush), .out_valid(a_ov),
        .out_ready(out_ready), .out_sum(a_sum), .out_ovf(a_ovf)
    );

    dot_accumulator #(.LEN(4), .ACC_W(33)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_rdy),
        .in_prod(in_prod), .flush(flush), .out_valid(b_ov),
        .out_ready(out_ready), .out_sum(b_sum), .out_ovf(b_ovf)
    );

    dot_accumulator #(.LEN(8), .ACC_W(40)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_rdy),
        .in_prod(in_prod), .flush(flush), .out_valid(c_ov),
        .out_ready(out_ready), .out_sum(c_sum), .out_ovf(c_ovf)
    );

    typedef struct {
        logic        v;
        logic [31:0] p;
        logic        ordy;
        logic        e_rdy;
        logic        e_ov;
        logic        chk;
        logic [47:0] e_sa;
        logic        e_oa;
        logic [47:0] e_sb;
        logic        e_ob;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string nm, input logic [47:0] act,
                       input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [31:0] p,
                       input logic f, input logic r);
        in_valid  = v;
        in_prod   = p;
        flush     = f;
        out_ready = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drv(1'b0, '0, 1'b0, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic vec_t mk(logic v, logic [31:0] p, logic ordy,
                                logic e_rdy, logic e_ov, logic chk_s,
                                logic [47:0] sa, logic oa,
                                logic [47:0] sb, logic ob);
        vec_t t;
        t.v = v; t.p = p; t.ordy = ordy;
        t.e_rdy = e_rdy; t.e_ov = e_ov; t.chk = chk_s;
        t.e_sa = sa; t.e_oa = oa; t.e_sb = sb; t.e_ob = ob;
        return t;
    endfunction

    localparam logic [31:0] BIG = 32'hFFFE_0001;

    initial begin
        tbl[0]  = mk(1, 1,       1, 1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 2,       1, 1, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 3,       1, 1, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 4,       1, 0, 1, 1, 10, 0, 10, 0);
        tbl[4]  = mk(1, 32'h12345, 1, 1, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, BIG,     1, 1, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, BIG,     1, 1, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(1, BIG,     1, 1, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(1, BIG,     1, 0, 1, 1, 48'h3_FFF8_0004, 0,
                     48'h1_FFFF_FFFF, 1);
        tbl[9]  = mk(1, 7,       1, 1, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(1, 1,       1, 1, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(1, 1,       1, 1, 0, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 1,       1, 1, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(1, 1,       1, 0, 1, 1, 4, 0, 4, 0);
        tbl[14] = mk(0, 0,       1, 1, 0, 0, 0, 0, 0, 0);

        // reset state
        do_reset();
        chk("rst_a_rdy", 48'(a_rdy), 1);
        chk("rst_a_ov",  48'(a_ov),  0);
        chk("rst_a_sum", 48'(a_sum), 0);
        chk("rst_a_ovf", 48'(a_ovf), 0);
        chk("rst_c_rdy", 48'(c_rdy), 1);

        // table: full frames, wide sum, saturation, held input ignored
        for (int i = 0; i < 15; i++) begin
            drv(tbl[i].v, tbl[i].p, 1'b0, tbl[i].ordy);
            step();
            chk($sformatf("t%0d_a_rdy", i), 48'(a_rdy), 48'(tbl[i].e_rdy));
            chk($sformatf("t%0d_a_ov", i), 48'(a_ov), 48'(tbl[i].e_ov));
            chk($sformatf("t%0d_b_ov", i), 48'(b_ov), 48'(tbl[i].e_ov));
            if (tbl[i].chk) begin
                chk($sformatf("t%0d_a_sum", i), 48'(a_sum), tbl[i].e_sa);
                chk($sformatf("t%0d_a_ovf", i), 48'(a_ovf), 48'(tbl[i].e_oa));
                chk($sformatf("t%0d_b_sum", i), 48'(b_sum), tbl[i].e_sb);
                chk($sformatf("t%0d_b_ovf", i), 48'(b_ovf), 48'(tbl[i].e_ob));
            end
        end

        // early flush on LEN=8, then flush with nothing pending
        do_reset();
        drv(1, 5, 0, 1);
        step();
        chk("fl_c_ov0", 48'(c_ov), 0);
        drv(1, 7, 1, 1);
        step();
        chk("fl_c_ov", 48'(c_ov), 1);
        chk("fl_c_sum", 48'(c_sum), 12);
        chk("fl_c_ovf", 48'(c_ovf), 0);
        chk("fl_c_rdy", 48'(c_rdy), 0);
        drv(0, 0, 0, 1);
        step();
        chk("fl_c_back", 48'(c_ov), 0);
        drv(0, 0, 1, 1);
        step();
        chk("fl_empty_ov", 48'(c_ov), 0);
        chk("fl_empty_rdy", 48'(c_rdy), 1);
        drv(0, 0, 0, 1);
        step();
        chk("fl_empty_ov2", 48'(c_ov), 0);

        // back-pressure: result held, inputs and flush not consumed
        do_reset();
        drv(1, 10, 0, 0); step();
        drv(1, 20, 0, 0); step();
        drv(1, 30, 0, 0); step();
        drv(1, 40, 0, 0); step();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_ov", k), 48'(a_ov), 1);
            chk($sformatf("bp%0d_rdy", k), 48'(a_rdy), 0);
            chk($sformatf("bp%0d_sum", k), 48'(a_sum), 100);
            drv(k[0], 999, 1, 0);
            step();
        end
        drv(0, 0, 0, 1);
        step();
        chk("bp_rel_ov", 48'(a_ov), 0);
        chk("bp_rel_rdy", 48'(a_rdy), 1);
        for (int k = 0; k < 4; k++) begin
            drv(1, 1, 0, 1);
            step();
        end
        chk("bp_next_ov", 48'(a_ov), 1);
        chk("bp_next_sum", 48'(a_sum), 4);

        // reset mid-frame beats a same-cycle handshake and flush
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drv(1, 9, 0, 1);
            step();
        end
        drv(1, 9, 1, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_ov", 48'(a_ov), 0);
        chk("mr_sum", 48'(a_sum), 0);
        chk("mr_ovf", 48'(a_ovf), 0);
        chk("mr_rdy", 48'(a_rdy), 1);
        for (int k = 0; k < 4; k++) begin
            drv(1, 2, 0, 0);
            step();
        end
        chk("mr_new_ov", 48'(a_ov), 1);
        chk("mr_new_sum", 48'(a_sum), 8);
        drv(0, 0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("hr_ov", 48'(a_ov), 0);
        chk("hr_sum", 48'(a_sum), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
